ahb_cmd_master: RTL and testbench

- Command-driven AHB bus initiator: converts single/INCR burst commands plus write/read data streams into arbitrated, pipelined AHB master transfers.
- It is the requesting end of the interface that ahb_iopmp slave ports (s*_h*, s*_hgrant_o) present, and is used as a DMA-style traffic source in front of the IOPMP.
- Handles grant loss, wait states, 1 KB boundary splitting and ERROR responses.

---
 rtl/ahb_enum_pkg.sv | 26 ++
 rtl/ahb_addr_incr.sv | 18 +
 rtl/ahb_cmd_master.sv | 180 ++++++++++++++++++
 tb/tb_ahb_cmd_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_enum_pkg.sv
// Shared AHB encodings and the command-master FSM state type.
// The master's optional RETRY/SPLIT reissue is enabled with AHB_MASTER_RETRY_EN (see ahb_cmd_master).
package ahb_enum;

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'b11;

  localparam logic [2:0] AHB_BURST_SINGLE = 3'b000;
  localparam logic [2:0] AHB_BURST_INCR   = 3'b001;

  localparam logic [1:0] AHB_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AHB_RESP_ERROR = 2'b01;
  localparam logic [1:0] AHB_RESP_RETRY = 2'b10;
  localparam logic [1:0] AHB_RESP_SPLIT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_LAST,
    S_ERR
  } ahb_master_state_t;

endpackage

// File: rtl/ahb_addr_incr.sv
// Next beat address for an INCR burst and a flag when that step leaves the current 1 KB page.
module ahb_addr_incr
  import ahb_enum::*;
#(
  parameter int A_WIDTH = 32
) (
  input  logic [A_WIDTH-1:0] addr,
  input  logic [2:0]         size,
  output logic [A_WIDTH-1:0] next_addr,
  output logic               cross_1k
);

  always_comb begin
    next_addr = addr + (A_WIDTH'(1) << size);
    cross_1k  = next_addr[A_WIDTH-1:10] != addr[A_WIDTH-1:10];
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// Command-driven AHB initiator: turns single/INCR commands into arbitrated, pipelined transfers.
// Define AHB_MASTER_RETRY_EN to reissue a beat after RETRY/SPLIT instead of aborting as on ERROR.
module ahb_cmd_master
  import ahb_enum::*;
#(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32,
  parameter int L_WIDTH = 8
) (
  input  logic               hclk_i,
  input  logic               hrst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [A_WIDTH-1:0] cmd_addr_i,
  input  logic               cmd_write_i,
  input  logic [2:0]         cmd_size_i,
  input  logic [L_WIDTH-1:0] cmd_len_i,
  input  logic [3:0]         cmd_prot_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [D_WIDTH-1:0] wr_data_i,
  output logic               rd_valid_o,
  output logic [D_WIDTH-1:0] rd_data_o,
  output logic               rd_last_o,
  output logic               done_o,
  output logic               err_o,
  output logic               hbusreq_o,
  input  logic               hgrant_i,
  output logic [A_WIDTH-1:0] haddr_o,
  output logic [3:0]         hprot_o,
  output logic [2:0]         hsize_o,
  output logic [1:0]         htrans_o,
  output logic [2:0]         hburst_o,
  output logic               hwrite_o,
  output logic [D_WIDTH-1:0] hwdata_o,
  input  logic [1:0]         hresp_i,
  input  logic               hready_i,
  input  logic [D_WIDTH-1:0] hrdata_i,
  output ahb_master_state_t  dbg_state_o
);

  localparam logic [L_WIDTH:0] BEAT_ONE = (L_WIDTH+1)'(1);

  ahb_master_state_t state, state_nxt;

  logic [A_WIDTH-1:0] addr_q, dp_addr_q, addr_nxt;
  logic [L_WIDTH:0]   beats_q;
  logic [D_WIDTH-1:0] hwdata_q;
  logic [2:0]         size_q, burst_q;
  logic [3:0]         prot_q;
  logic               write_q, own_q, first_q, dp_valid_q, replay_q;
  logic               cross_1k, accept_cmd, issue, data_ok, resp_fail, retry_hit, err_hit;

  ahb_addr_incr #(.A_WIDTH(A_WIDTH)) u_incr (
    .addr      (addr_q),
    .size      (size_q),
    .next_addr (addr_nxt),
    .cross_1k  (cross_1k)
  );

  // Handshakes: cmd and wr beats transfer on a cycle where valid && ready are both high;
  // rd_valid_o is a single-cycle strobe with no backpressure.
  assign accept_cmd = cmd_valid_i && cmd_ready_o;
  assign data_ok    = dp_valid_q && hready_i && (hresp_i == AHB_RESP_OKAY);
  assign resp_fail  = dp_valid_q && !hready_i && (hresp_i != AHB_RESP_OKAY);
`ifdef AHB_MASTER_RETRY_EN
  assign retry_hit  = resp_fail && (hresp_i != AHB_RESP_ERROR);
`else
  assign retry_hit  = 1'b0;
`endif
  assign err_hit    = resp_fail && !retry_hit;

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    htrans_o  = AHB_TRANS_IDLE;
    hbusreq_o = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    case (state)
      S_IDLE: if (accept_cmd) state_nxt = S_REQ;
      S_REQ: begin
        hbusreq_o = 1'b1;
        if (hgrant_i && hready_i) state_nxt = S_XFER;
      end
      S_XFER: begin
        hbusreq_o = 1'b1;
        // A write beat without data stalls: IDLE if it starts a sequence, BUSY mid-burst.
        if (own_q) begin
          if (write_q && !replay_q && !wr_valid_i)
            htrans_o = first_q ? AHB_TRANS_IDLE : AHB_TRANS_BUSY;
          else
            htrans_o = first_q ? AHB_TRANS_NONSEQ : AHB_TRANS_SEQ;
        end
        if (hready_i && htrans_o[1] && beats_q == BEAT_ONE) state_nxt = S_LAST;
      end
      S_LAST: if (data_ok) begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: if (hready_i) begin
        done_o    = 1'b1;
        err_o     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (retry_hit) state_nxt = S_REQ;
    if (err_hit)   state_nxt = S_ERR;
  end

  assign issue       = (state == S_XFER) && htrans_o[1] && hready_i;
  assign wr_ready_o  = issue && write_q && !replay_q;
  assign rd_valid_o  = data_ok && !write_q;
  assign rd_data_o   = rd_valid_o ? hrdata_i : '0;
  assign rd_last_o   = rd_valid_o && (state == S_LAST);
  assign cmd_ready_o = (state == S_IDLE) && !hrst_i;
  assign haddr_o     = addr_q;
  assign hsize_o     = size_q;
  assign hprot_o     = prot_q;
  assign hburst_o    = burst_q;
  assign hwrite_o    = write_q;
  assign hwdata_o    = hwdata_q;
  assign dbg_state_o = state;

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) begin
      addr_q     <= '0;
      dp_addr_q  <= '0;
      beats_q    <= '0;
      hwdata_q   <= '0;
      size_q     <= '0;
      burst_q    <= AHB_BURST_SINGLE;
      prot_q     <= '0;
      write_q    <= 1'b0;
      own_q      <= 1'b0;
      first_q    <= 1'b0;
      dp_valid_q <= 1'b0;
      replay_q   <= 1'b0;
    end else begin
      if (hready_i) begin
        own_q      <= hgrant_i;
        dp_valid_q <= issue;
      end
      if (accept_cmd) begin
        addr_q   <= cmd_addr_i;
        size_q   <= cmd_size_i;
        prot_q   <= cmd_prot_i;
        write_q  <= cmd_write_i;
        burst_q  <= (cmd_len_i == '0) ? AHB_BURST_SINGLE : AHB_BURST_INCR;
        beats_q  <= {1'b0, cmd_len_i} + BEAT_ONE;
        first_q  <= 1'b1;
        replay_q <= 1'b0;
      end
      // Losing the address bus forces the next beat to restart the sequence.
      if (state == S_XFER && !own_q) first_q <= 1'b1;
      if (issue) begin
        addr_q    <= addr_nxt;
        dp_addr_q <= addr_q;
        beats_q   <= beats_q - BEAT_ONE;
        first_q   <= cross_1k;
        replay_q  <= 1'b0;
        if (write_q && !replay_q) hwdata_q <= wr_data_i;
      end
      if (resp_fail) dp_valid_q <= 1'b0;
      // Rewind to the failed beat; its write data is still sitting in hwdata_q.
      if (retry_hit) begin
        addr_q   <= dp_addr_q;
        beats_q  <= beats_q + BEAT_ONE;
        first_q  <= 1'b1;
        replay_q <= write_q;
      end
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: writes, reads, wait states, 1 KB split, BUSY, ERROR, grant loss,
// reset mid-burst, and (with AHB_MASTER_RETRY_EN) RETRY reissue.
module tb_ahb_cmd_master;
  import ahb_enum::*;

  logic              hclk_i = 1'b0;
  logic              hrst_i;
  logic              cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0]       cmd_addr_i;
  logic [2:0]        cmd_size_i;
  logic [7:0]        cmd_len_i;
  logic [3:0]        cmd_prot_i;
  logic              wr_valid_i, wr_ready_o;
  logic [31:0]       wr_data_i;
  logic              rd_valid_o, rd_last_o, done_o, err_o;
  logic [31:0]       rd_data_o;
  logic              hbusreq_o, hgrant_i, hwrite_o, hready_i;
  logic [31:0]       haddr_o, hwdata_o, hrdata_i;
  logic [3:0]        hprot_o;
  logic [2:0]        hsize_o, hburst_o;
  logic [1:0]        htrans_o, hresp_i;
  ahb_master_state_t dbg_state_o;

  int checks = 0;
  int errors = 0;

  always #5 hclk_i = ~hclk_i;

  ahb_cmd_master #(.A_WIDTH(32), .D_WIDTH(32), .L_WIDTH(8)) dut (
    .hclk_i(hclk_i), .hrst_i(hrst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_write_i(cmd_write_i), .cmd_size_i(cmd_size_i), .cmd_len_i(cmd_len_i), .cmd_prot_i(cmd_prot_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .done_o(done_o), .err_o(err_o), .hbusreq_o(hbusreq_o), .hgrant_i(hgrant_i),
    .haddr_o(haddr_o), .hprot_o(hprot_o), .hsize_o(hsize_o), .htrans_o(htrans_o),
    .hburst_o(hburst_o), .hwrite_o(hwrite_o), .hwdata_o(hwdata_o),
    .hresp_i(hresp_i), .hready_i(hready_i), .hrdata_i(hrdata_i), .dbg_state_o(dbg_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge hclk_i);
  endtask

  task automatic bus(input string tag, input logic [1:0] trans, input logic [31:0] addr);
    chk({tag, "_htrans"}, 32'(trans), 32'(htrans_o));
    chk({tag, "_haddr"}, haddr_o, addr);
  endtask

  task automatic cmd(input logic [31:0] addr, input logic wr, input logic [7:0] len);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_write_i = wr;
    cmd_size_i  = 3'd2;
    cmd_len_i   = len;
    cmd_prot_i  = 4'h3;
  endtask

  initial begin
    hrst_i = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_write_i = 1'b0; cmd_size_i = '0;
    cmd_len_i = '0; cmd_prot_i = '0; wr_valid_i = 1'b0; wr_data_i = '0; hgrant_i = 1'b0;
    hready_i = 1'b1; hresp_i = AHB_RESP_OKAY; hrdata_i = '0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 0);
    chk("rst_htrans", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    chk("rst_busreq", 32'(hbusreq_o), 0);
    chk("rst_haddr", haddr_o, 0);
    chk("rst_state", 32'(dbg_state_o), 32'(S_IDLE));
    tick(); hrst_i = 1'b0; #1;
    chk("idle_cmd_ready", 32'(cmd_ready_o), 1);

    // Single write, immediate grant
    tick(); cmd(32'h2000_0000, 1'b1, 8'd0); hgrant_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 32'hA5A5_0001; #1;
    chk("t1_cmd_ready", 32'(cmd_ready_o), 1);
    tick(); cmd_valid_i = 1'b0; #1;
    chk("t1_req_busreq", 32'(hbusreq_o), 1);
    chk("t1_req_htrans", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    tick(); #1;
    bus("t1_b1", AHB_TRANS_NONSEQ, 32'h2000_0000);
    chk("t1_hburst", 32'(hburst_o), 32'(AHB_BURST_SINGLE));
    chk("t1_wr_ready", 32'(wr_ready_o), 1);
    tick(); wr_valid_i = 1'b0; #1;
    chk("t1_hwdata", hwdata_o, 32'hA5A5_0001);
    chk("t1_htrans_last", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    chk("t1_done", 32'(done_o), 1);
    chk("t1_err", 32'(err_o), 0);
    tick(); #1;
    chk("t1_done_clear", 32'(done_o), 0);
    chk("t1_cmd_ready_again", 32'(cmd_ready_o), 1);

    // 4-beat INCR read with two wait states on beat 2
    tick(); cmd(32'h4000_0010, 1'b0, 8'd3);
    tick(); cmd_valid_i = 1'b0;
    tick(); #1;
    bus("t2_b1", AHB_TRANS_NONSEQ, 32'h4000_0010);
    chk("t2_hburst", 32'(hburst_o), 32'(AHB_BURST_INCR));
    chk("t2_rd_valid_b1a", 32'(rd_valid_o), 0);
    tick(); hrdata_i = 32'hD000_0001; #1;
    bus("t2_b2", AHB_TRANS_SEQ, 32'h4000_0014);
    chk("t2_rd_valid1", 32'(rd_valid_o), 1);
    chk("t2_rd_data1", rd_data_o, 32'hD000_0001);
    tick(); hready_i = 1'b0; #1;
    bus("t2_wait1", AHB_TRANS_SEQ, 32'h4000_0018);
    chk("t2_rd_valid_wait", 32'(rd_valid_o), 0);
    tick(); #1;
    bus("t2_wait2", AHB_TRANS_SEQ, 32'h4000_0018);
    tick(); hready_i = 1'b1; hrdata_i = 32'hD000_0002; #1;
    bus("t2_b3", AHB_TRANS_SEQ, 32'h4000_0018);
    chk("t2_rd_data2", rd_data_o, 32'hD000_0002);
    tick(); hrdata_i = 32'hD000_0003; #1;
    bus("t2_b4", AHB_TRANS_SEQ, 32'h4000_001C);
    chk("t2_rd_data3", rd_data_o, 32'hD000_0003);
    chk("t2_rd_last3", 32'(rd_last_o), 0);
    tick(); hrdata_i = 32'hD000_0004; #1;
    chk("t2_htrans_end", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    chk("t2_rd_data4", rd_data_o, 32'hD000_0004);
    chk("t2_rd_last4", 32'(rd_last_o), 1);
    chk("t2_done", 32'(done_o), 1);
    chk("t2_err", 32'(err_o), 0);

    // 4-beat write crossing a 1 KB boundary
    tick(); cmd(32'h4000_03F8, 1'b1, 8'd3); wr_valid_i = 1'b1; wr_data_i = 32'hB000_0001;
    tick(); cmd_valid_i = 1'b0;
    tick(); #1;
    bus("t3_b1", AHB_TRANS_NONSEQ, 32'h4000_03F8);
    tick(); wr_data_i = 32'hB000_0002; #1;
    bus("t3_b2", AHB_TRANS_SEQ, 32'h4000_03FC);
    chk("t3_hwdata1", hwdata_o, 32'hB000_0001);
    tick(); wr_data_i = 32'hB000_0003; #1;
    bus("t3_b3", AHB_TRANS_NONSEQ, 32'h4000_0400);
    chk("t3_hwdata2", hwdata_o, 32'hB000_0002);
    tick(); wr_data_i = 32'hB000_0004; #1;
    bus("t3_b4", AHB_TRANS_SEQ, 32'h4000_0404);
    tick(); wr_valid_i = 1'b0; #1;
    chk("t3_hwdata4", hwdata_o, 32'hB000_0004);
    chk("t3_busreq_end", 32'(hbusreq_o), 0);
    chk("t3_done", 32'(done_o), 1);

    // Write burst with a one-cycle data gap before beat 3
    tick(); cmd(32'h5000_0000, 1'b1, 8'd3); wr_valid_i = 1'b1; wr_data_i = 32'hC000_0001;
    tick(); cmd_valid_i = 1'b0;
    tick(); #1;
    bus("t4_b1", AHB_TRANS_NONSEQ, 32'h5000_0000);
    tick(); wr_data_i = 32'hC000_0002; #1;
    bus("t4_b2", AHB_TRANS_SEQ, 32'h5000_0004);
    tick(); wr_valid_i = 1'b0; #1;
    bus("t4_busy", AHB_TRANS_BUSY, 32'h5000_0008);
    chk("t4_wr_ready_busy", 32'(wr_ready_o), 0);
    chk("t4_hwdata_busy", hwdata_o, 32'hC000_0002);
    tick(); wr_valid_i = 1'b1; wr_data_i = 32'hC000_0003; #1;
    bus("t4_b3", AHB_TRANS_SEQ, 32'h5000_0008);
    chk("t4_wr_ready_b3", 32'(wr_ready_o), 1);
    tick(); wr_data_i = 32'hC000_0004; #1;
    bus("t4_b4", AHB_TRANS_SEQ, 32'h5000_000C);
    tick(); wr_valid_i = 1'b0; #1;
    chk("t4_hwdata4", hwdata_o, 32'hC000_0004);
    chk("t4_done", 32'(done_o), 1);

    // ERROR on beat 2 of a 4-beat read
    tick(); cmd(32'h6000_0000, 1'b0, 8'd3);
    tick(); cmd_valid_i = 1'b0;
    tick(); #1;
    bus("t5_b1", AHB_TRANS_NONSEQ, 32'h6000_0000);
    tick(); #1;
    bus("t5_b2", AHB_TRANS_SEQ, 32'h6000_0004);
    tick(); hready_i = 1'b0; hresp_i = AHB_RESP_ERROR; #1;
    chk("t5_rd_valid_err1", 32'(rd_valid_o), 0);
    chk("t5_done_err1", 32'(done_o), 0);
    tick(); hready_i = 1'b1; #1;
    chk("t5_htrans_err2", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    chk("t5_done", 32'(done_o), 1);
    chk("t5_err", 32'(err_o), 1);
    chk("t5_busreq", 32'(hbusreq_o), 0);
    tick(); hresp_i = AHB_RESP_OKAY; #1;
    chk("t5_htrans_after", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    chk("t5_done_clear", 32'(done_o), 0);
    chk("t5_cmd_ready", 32'(cmd_ready_o), 1);

    // Grant lost after beat 1 of 3, re-granted three cycles later
    tick(); cmd(32'h7000_0000, 1'b0, 8'd2);
    tick(); cmd_valid_i = 1'b0;
    tick(); hgrant_i = 1'b0; #1;
    bus("t6_b1", AHB_TRANS_NONSEQ, 32'h7000_0000);
    tick(); #1;
    chk("t6_idle1", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    chk("t6_busreq_kept", 32'(hbusreq_o), 1);
    chk("t6_rd_valid1", 32'(rd_valid_o), 1);
    tick(); #1;
    chk("t6_idle2", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    tick(); hgrant_i = 1'b1; #1;
    chk("t6_idle3", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    tick(); #1;
    bus("t6_b2", AHB_TRANS_NONSEQ, 32'h7000_0004);
    tick(); #1;
    bus("t6_b3", AHB_TRANS_SEQ, 32'h7000_0008);
    tick(); #1;
    chk("t6_rd_last", 32'(rd_last_o), 1);
    chk("t6_done", 32'(done_o), 1);

`ifdef AHB_MASTER_RETRY_EN
    // RETRY on beat 2 of 3 reissues beat 2 after re-arbitration
    tick(); cmd(32'h8000_0000, 1'b0, 8'd2);
    tick(); cmd_valid_i = 1'b0;
    tick(); #1;
    bus("t7_b1", AHB_TRANS_NONSEQ, 32'h8000_0000);
    tick(); #1;
    bus("t7_b2", AHB_TRANS_SEQ, 32'h8000_0004);
    tick(); hready_i = 1'b0; hresp_i = AHB_RESP_RETRY; #1;
    chk("t7_rd_valid_retry", 32'(rd_valid_o), 0);
    tick(); hready_i = 1'b1; hgrant_i = 1'b0; #1;
    chk("t7_idle_retry", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    chk("t7_busreq", 32'(hbusreq_o), 1);
    chk("t7_no_done", 32'(done_o), 0);
    tick(); hgrant_i = 1'b1; hresp_i = AHB_RESP_OKAY; #1;
    chk("t7_idle_rearb", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    tick(); #1;
    bus("t7_b2_again", AHB_TRANS_NONSEQ, 32'h8000_0004);
    tick(); #1;
    bus("t7_b3", AHB_TRANS_SEQ, 32'h8000_0008);
    tick(); #1;
    chk("t7_done", 32'(done_o), 1);
    chk("t7_err", 32'(err_o), 0);
`endif

    // Reset in the middle of a burst: abandoned with no done
    tick(); cmd(32'h9000_0000, 1'b0, 8'd3);
    tick(); cmd_valid_i = 1'b0;
    tick(); #1;
    bus("t8_b1", AHB_TRANS_NONSEQ, 32'h9000_0000);
    tick(); hrst_i = 1'b1; #1;
    chk("t8_rst_htrans", 32'(htrans_o), 32'(AHB_TRANS_IDLE));
    chk("t8_rst_done", 32'(done_o), 0);
    chk("t8_rst_cmd_ready", 32'(cmd_ready_o), 0);
    chk("t8_rst_busreq", 32'(hbusreq_o), 0);
    tick(); hrst_i = 1'b0; #1;
    chk("t8_cmd_ready", 32'(cmd_ready_o), 1);
    chk("t8_done_after", 32'(done_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
